sap_ram_arbiter: RTL and testbench

SAP_RAM_ARBITER -- requirements
Module: sap_ram_arbiter

---
 rtl/sap_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_sap_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_ram_arbiter.sv
// RAM port arbiter between the SAP CPU strobes and an external loader with burst limiting.
// Define SAP_RAM_ARB_READBACK_EN to let the loader read RAM; otherwise loader reads are rejected with ld_err.
module sap_ram_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_maddr_latch,
    input  logic              cpu_ram_latch,
    input  logic              cpu_ram_out,
    input  logic [DATA_W-1:0] cpu_bus,
    input  logic              ld_req,
    input  logic              ld_valid,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              cpu_stall,
    output logic              ld_gnt,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err
);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_WAIT,
        ST_LOAD,
        ST_HOLDOFF
    } state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              stall_q, gnt_q, ack_q, err_q, err_d;
    logic              accept, cpu_idle;

`ifndef SAP_RAM_ARB_READBACK_EN
    logic rdata_unused;
    assign rdata_unused = ^ram_rdata;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = 8'd0;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        ram_addr  = mar_q;
        ram_wdata = cpu_bus;
        ram_we    = cpu_ram_latch;
        accept    = (state_q == ST_LOAD) && ld_valid;
        cpu_idle  = !(cpu_maddr_latch || cpu_ram_latch || cpu_ram_out);

        case (state_q)
            ST_CPU: begin
                if (ld_req) state_d = ST_WAIT;
            end
            // The CPU keeps the RAM until its in-flight strobes are finished.
            ST_WAIT: begin
                if (!ld_req)       state_d = ST_CPU;
                else if (cpu_idle) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
                ram_we    = ld_valid && ld_we;
                cnt_d     = accept ? cnt_q + 8'd1 : cnt_q;
                if (!ld_req)                                       state_d = ST_CPU;
                else if (accept && (cnt_q + 8'd1) == BURST_LIMIT)  state_d = ST_HOLDOFF;
                if (accept && !ld_we) begin
`ifdef SAP_RAM_ARB_READBACK_EN
                    rdata_d = ram_rdata;
`else
                    err_d   = 1'b1;
`endif
                end
            end
            ST_HOLDOFF: begin
                state_d = ST_CPU;
            end
            default: state_d = ST_CPU;
        endcase

        if (reset) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CPU;
            mar_q   <= '0;
            cnt_q   <= 8'd0;
            rdata_q <= '0;
            stall_q <= 1'b0;
            gnt_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cpu_maddr_latch) mar_q <= cpu_bus[ADDR_W-1:0];
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            stall_q <= (state_d == ST_WAIT) || (state_d == ST_LOAD);
            gnt_q   <= (state_d == ST_LOAD);
            ack_q   <= accept;
            err_q   <= err_d;
        end
    end

    assign cpu_stall = stall_q;
    assign ld_gnt    = gnt_q;
    assign ld_ack    = ack_q;
    assign ld_rdata  = rdata_q;
    assign ld_err    = err_q;

endmodule

// File: tb/tb_sap_ram_arbiter.sv
// Self-checking bench for sap_ram_arbiter: directed scenarios plus a randomized loader run
// scored against a transaction-level model of acks, read data and RAM contents.
module tb_sap_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MB = 16;
`ifdef SAP_RAM_ARB_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_maddr_latch, cpu_ram_latch, cpu_ram_out;
    logic [DW-1:0] cpu_bus;
    logic          ld_req, ld_valid, ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we, cpu_stall, ld_gnt, ld_ack, ld_err;
    logic [DW-1:0] ld_rdata;

    logic [DW-1:0] mem [16] = '{default: 8'h00};
    logic [DW-1:0] modelRdata;
    int            passCount = 0;
    int            checkCount = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: asynchronous read, write on the rising edge.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    sap_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .cpu_maddr_latch(cpu_maddr_latch), .cpu_ram_latch(cpu_ram_latch),
        .cpu_ram_out(cpu_ram_out), .cpu_bus(cpu_bus),
        .ld_req(ld_req), .ld_valid(ld_valid), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ram_rdata(ram_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .cpu_stall(cpu_stall), .ld_gnt(ld_gnt), .ld_ack(ld_ack),
        .ld_rdata(ld_rdata), .ld_err(ld_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        cpu_maddr_latch = 1'b0; cpu_ram_latch = 1'b0; cpu_ram_out = 1'b0;
        cpu_bus = '0; ld_req = 1'b0; ld_valid = 1'b0; ld_we = 1'b0;
        ld_addr = '0; ld_wdata = '0;
    endtask

    task automatic grantLoader();
        ld_req = 1'b1;
        for (int i = 0; i < 8 && ld_gnt !== 1'b1; i++) step();
        checkCount++; if (ld_gnt !== 1'b1) $display("[TB] FAIL grant_timeout: ld_gnt=%b want 1", ld_gnt); else passCount++;
    endtask

    task automatic test_reset();
        idleInputs();
        ld_req = 1'b1; ld_valid = 1'b1; ld_we = 1'b1; cpu_ram_latch = 1'b1;
        reset = 1'b1;
        #1;
        checkCount++; if (ram_we !== 1'b0) $display("[TB] FAIL reset_ram_we: got %b want 0", ram_we); else passCount++;
        step(); step();
        checkCount++; if ({cpu_stall, ld_gnt, ld_ack, ld_err} !== 4'b0000)
            $display("[TB] FAIL reset_flags: stall/gnt/ack/err=%b want 0000", {cpu_stall, ld_gnt, ld_ack, ld_err}); else passCount++;
        checkCount++; if (ld_rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h want 00", ld_rdata); else passCount++;
        reset = 1'b0;
        idleInputs();
        modelRdata = 8'h00;
        step();
        checkCount++; if (ram_addr !== 4'h0) $display("[TB] FAIL reset_mar: ram_addr=%h want 0", ram_addr); else passCount++;
    endtask

    task automatic test_grant();
        idleInputs();
        ld_req = 1'b1;
        step();
        checkCount++; if ({cpu_stall, ld_gnt} !== 2'b10) $display("[TB] FAIL grant_cycle1: stall/gnt=%b want 10", {cpu_stall, ld_gnt}); else passCount++;
        step();
        checkCount++; if (ld_gnt !== 1'b1) $display("[TB] FAIL grant_cycle2: ld_gnt=%b want 1", ld_gnt); else passCount++;
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'h5; ld_wdata = 8'h3A;
        #1;
        checkCount++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 4'h5, 8'h3A})
            $display("[TB] FAIL grant_write_route: we/addr/data=%b/%h/%h want 1/5/3a", ram_we, ram_addr, ram_wdata); else passCount++;
        step();
        checkCount++; if ({ld_ack, ld_err} !== 2'b10) $display("[TB] FAIL grant_ack: ack/err=%b want 10", {ld_ack, ld_err}); else passCount++;
        checkCount++; if (mem[5] !== 8'h3A) $display("[TB] FAIL grant_mem: mem[5]=%h want 3a", mem[5]); else passCount++;
        ld_valid = 1'b0; ld_req = 1'b0;
        step();
        checkCount++; if ({cpu_stall, ld_gnt, ld_ack} !== 3'b000)
            $display("[TB] FAIL grant_release: stall/gnt/ack=%b want 000", {cpu_stall, ld_gnt, ld_ack}); else passCount++;
    endtask

    task automatic test_cpu_priority();
        idleInputs();
        cpu_maddr_latch = 1'b1; cpu_bus = 8'h09;
        step();
        idleInputs();
        cpu_ram_out = 1'b1; ld_req = 1'b1;
        step();
        checkCount++; if ({cpu_stall, ld_gnt, ram_addr} !== {2'b10, 4'h9})
            $display("[TB] FAIL prio_wait1: stall/gnt/addr=%b/%b/%h want 1/0/9", cpu_stall, ld_gnt, ram_addr); else passCount++;
        step();
        checkCount++; if ({cpu_stall, ld_gnt} !== 2'b10) $display("[TB] FAIL prio_wait2: stall/gnt=%b want 10", {cpu_stall, ld_gnt}); else passCount++;
        cpu_ram_out = 1'b0;
        step();
        checkCount++; if (ld_gnt !== 1'b1) $display("[TB] FAIL prio_grant: ld_gnt=%b want 1", ld_gnt); else passCount++;
        ld_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] data [20];
        int sent = 0, acks = 0, acksBeforeGap = -1, stallLow = 0, gntLow = 0;
        for (int k = 0; k < 20; k++) data[k] = 8'($urandom);
        idleInputs();
        ld_req = 1'b1; ld_we = 1'b1;
        for (int cyc = 0; cyc < 80 && acks < 20; cyc++) begin
            ld_valid = (sent < 20);
            ld_addr  = AW'(sent);
            ld_wdata = (sent < 20) ? data[sent] : 8'h00;
            #1;
            if (ld_gnt && ld_valid) sent++;
            step();
            if (ld_ack) acks++;
            if (sent > 0 && sent < 20 && !ld_gnt) begin
                if (acksBeforeGap < 0) acksBeforeGap = acks;
                gntLow++;
                if (!cpu_stall) stallLow++;
            end
        end
        checkCount++; if (acks !== 20) $display("[TB] FAIL burst_total_acks: got %0d want 20", acks); else passCount++;
        checkCount++; if (acksBeforeGap !== MB) $display("[TB] FAIL burst_first_grant: got %0d acks want %0d", acksBeforeGap, MB); else passCount++;
        checkCount++; if (stallLow !== 2) $display("[TB] FAIL burst_stall_gap: got %0d cycles want 2", stallLow); else passCount++;
        checkCount++; if (gntLow !== 3) $display("[TB] FAIL burst_gnt_gap: got %0d cycles want 3", gntLow); else passCount++;
        for (int a = 0; a < 16; a++) begin
            checkCount++; if (mem[a] !== data[(a < 4) ? a + 16 : a])
                $display("[TB] FAIL burst_mem[%0d]: got %h want %h", a, mem[a], data[(a < 4) ? a + 16 : a]); else passCount++;
        end
        idleInputs();
        step(); step();
    endtask

    task automatic test_read();
        idleInputs();
        grantLoader();
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'h7; ld_wdata = 8'hC4;
        step();
        ld_we = 1'b0;
        step();
        checkCount++; if (ld_ack !== 1'b1) $display("[TB] FAIL read_ack: got %b want 1", ld_ack); else passCount++;
        checkCount++; if (ld_err !== !READBACK) $display("[TB] FAIL read_err: got %b want %b", ld_err, !READBACK); else passCount++;
        if (READBACK) modelRdata = 8'hC4;
        checkCount++; if (ld_rdata !== modelRdata) $display("[TB] FAIL read_data: got %h want %h", ld_rdata, modelRdata); else passCount++;
        idleInputs();
        step();
        checkCount++; if ({ld_ack, ld_err} !== 2'b00) $display("[TB] FAIL read_pulse: ack/err=%b want 00", {ld_ack, ld_err}); else passCount++;
    endtask

    task automatic test_reset_mid_burst();
        idleInputs();
        grantLoader();
        ld_valid = 1'b1; ld_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_addr = AW'(8 + i); ld_wdata = 8'($urandom);
            step();
        end
        checkCount++; if (ld_ack !== 1'b1) $display("[TB] FAIL midrst_pre_ack: got %b want 1", ld_ack); else passCount++;
        reset = 1'b1;
        ld_addr = 4'hB;
        #1;
        checkCount++; if (ram_we !== 1'b0) $display("[TB] FAIL midrst_ram_we: got %b want 0", ram_we); else passCount++;
        step();
        modelRdata = 8'h00;
        checkCount++; if ({cpu_stall, ld_gnt, ld_ack, ld_err, ld_rdata} !== 12'h000)
            $display("[TB] FAIL midrst_outputs: stall/gnt/ack/err=%b rdata=%h want 0000/00", {cpu_stall, ld_gnt, ld_ack, ld_err}, ld_rdata); else passCount++;
        reset = 1'b0; ld_req = 1'b0;
        step();
        checkCount++; if ({ld_gnt, ld_ack} !== 2'b00) $display("[TB] FAIL midrst_after: gnt/ack=%b want 00", {ld_gnt, ld_ack}); else passCount++;
        idleInputs();
    endtask

    task automatic test_mar();
        idleInputs();
        grantLoader();
        cpu_maddr_latch = 1'b1; cpu_ram_latch = 1'b1; cpu_bus = 8'h0F; ld_addr = 4'h2;
        #1;
        checkCount++; if ({ram_we, ram_addr} !== {1'b0, 4'h2})
            $display("[TB] FAIL mar_block: we/addr=%b/%h want 0/2", ram_we, ram_addr); else passCount++;
        step();
        idleInputs();
        step();
        #1;
        checkCount++; if ({ld_gnt, ram_addr} !== {1'b0, 4'hF})
            $display("[TB] FAIL mar_after_release: gnt/addr=%b/%h want 0/f", ld_gnt, ram_addr); else passCount++;
    endtask

    task automatic test_random();
        logic [DW-1:0] memRef [16];
        logic          pendAck = 1'b0, pendErr = 1'b0, expectGntLow = 1'b0;
        logic [DW-1:0] pendRdata = '0;
        int            runCount = 0;
        idleInputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        modelRdata = 8'h00;
        for (int a = 0; a < 16; a++) memRef[a] = mem[a];
        for (int cyc = 0; cyc < 400; cyc++) begin
            checkCount++; if (ld_ack !== pendAck) $display("[TB] FAIL rand_ack@%0d: got %b want %b", cyc, ld_ack, pendAck); else passCount++;
            if (pendAck) begin
                checkCount++; if (ld_err !== pendErr) $display("[TB] FAIL rand_err@%0d: got %b want %b", cyc, ld_err, pendErr); else passCount++;
                checkCount++; if (ld_rdata !== pendRdata) $display("[TB] FAIL rand_rdata@%0d: got %h want %h", cyc, ld_rdata, pendRdata); else passCount++;
            end
            if (expectGntLow) begin
                checkCount++; if (ld_gnt !== 1'b0) $display("[TB] FAIL rand_gnt_drop@%0d: got %b want 0", cyc, ld_gnt); else passCount++;
            end
            if (!ld_gnt) runCount = 0;
            ld_req   = ($urandom_range(0, 19) != 0);
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = AW'($urandom);
            ld_wdata = DW'($urandom);
            #1;
            checkCount++; if (ram_we !== (ld_gnt & ld_valid & ld_we))
                $display("[TB] FAIL rand_ram_we@%0d: got %b want %b", cyc, ram_we, ld_gnt & ld_valid & ld_we); else passCount++;
            pendAck = ld_gnt && ld_valid;
            if (pendAck) begin
                runCount++;
                if (ld_we) begin
                    memRef[ld_addr] = ld_wdata;
                    pendErr = 1'b0;
                end else if (READBACK) begin
                    modelRdata = memRef[ld_addr];
                    pendErr = 1'b0;
                end else begin
                    pendErr = 1'b1;
                end
                pendRdata = modelRdata;
            end
            expectGntLow = (pendAck && runCount == MB) || (ld_gnt && !ld_req);
            step();
        end
        for (int a = 0; a < 16; a++) begin
            checkCount++; if (mem[a] !== memRef[a]) $display("[TB] FAIL rand_mem[%0d]: got %h want %h", a, mem[a], memRef[a]); else passCount++;
        end
        idleInputs();
        step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        modelRdata = 8'h00;
        test_reset();
        test_grant();
        test_cpu_priority();
        test_back_to_back();
        test_read();
        test_reset_mid_burst();
        test_mar();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
